// File: rtl/rsa_operand_fetch.sv
// Operand fetch for the RSA core: streams key, modulus and message words out of the
// operand SRAM, LSW first, through a 2-entry FIFO that hides the SRAM read latency.

module rsa_operand_fetch_chk (
   input logic       clk,
   input logic       rst,
   input logic       push,
   input logic       pop,
   input logic [1:0] count
);
   // A push into a full FIFO without a matching pop would lose a word.
   a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && !pop && (count == 2'd2)));
   a_count_bound: assert property (@(posedge clk) disable iff (rst) (count <= 2'd2));
endmodule

module rsa_operand_fetch #(
   parameter int ADDR_W   = 8,
   parameter int DATA_W   = 32,
   parameter int WORDS    = 64,
   parameter int MSG_BASE = 0,
   parameter int KEY_BASE = 64,
   parameter int N_BASE   = 128
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              sram_en,
   output logic [ADDR_W-1:0] sram_addr,
   input  logic [DATA_W-1:0] sram_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        out_sel,
   output logic [5:0]        out_idx,
   output logic              out_last
);
   localparam int IDX_W = 6;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [1:0]          sel_q, sel_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [ADDR_W-1:0]   addr_hold_q, addr_hold_d;
   logic                inflight_q, inflight_d;
   logic [1:0]          pipe_sel_q, pipe_sel_d;
   logic [IDX_W-1:0]    pipe_idx_q, pipe_idx_d;
   logic [DATA_W-1:0]   f_data_q [2];
   logic [DATA_W-1:0]   f_data_d [2];
   logic [1:0]          f_sel_q [2];
   logic [1:0]          f_sel_d [2];
   logic [IDX_W-1:0]    f_idx_q [2];
   logic [IDX_W-1:0]    f_idx_d [2];
   logic                wr_ptr_q, wr_ptr_d;
   logic                rd_ptr_q, rd_ptr_d;
   logic [1:0]          count_q, count_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;

   logic                push_s, pop_s, issue_s, last_issue_s;
   logic [2:0]          occ_s;
   logic [ADDR_W-1:0]   base_s, cur_addr_s;

   // Issue decision: at most two words may be held between the SRAM pipe and the FIFO.
   always_comb begin
      pop_s        = (count_q != 2'd0) && out_ready;
      push_s       = inflight_q;
      occ_s        = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop_s};
      issue_s      = (state_q == S_FETCH) && (occ_s < 3'd2);
      last_issue_s = issue_s && (sel_q == 2'd2) && (idx_q == LAST_IDX);
      case (sel_q)
         2'd0:    base_s = ADDR_W'(KEY_BASE);
         2'd1:    base_s = ADDR_W'(N_BASE);
         default: base_s = ADDR_W'(MSG_BASE);
      endcase
      cur_addr_s = base_s + ADDR_W'(idx_q);
   end

   // Sequencer: operand/word counters and the IDLE-FETCH-DRAIN-DONE state machine.
   always_comb begin
      state_d     = state_q;
      sel_d       = sel_q;
      idx_d       = idx_q;
      inflight_d  = issue_s;
      pipe_sel_d  = pipe_sel_q;
      pipe_idx_d  = pipe_idx_q;
      addr_hold_d = addr_hold_q;
      if (issue_s) begin
         addr_hold_d = cur_addr_s;
         pipe_sel_d  = sel_q;
         pipe_idx_d  = idx_q;
      end else begin
         addr_hold_d = addr_hold_q;
      end
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_FETCH;
               sel_d   = 2'd0;
               idx_d   = {IDX_W{1'b0}};
            end else begin
               state_d = S_IDLE;
            end
         end
         S_FETCH: begin
            if (issue_s) begin
               if (idx_q == LAST_IDX) begin
                  idx_d = {IDX_W{1'b0}};
                  sel_d = sel_q + 2'd1;
               end else begin
                  idx_d = idx_q + {{(IDX_W-1){1'b0}}, 1'b1};
               end
            end else begin
               idx_d = idx_q;
            end
            if (last_issue_s) begin
               state_d = S_DRAIN;
            end else begin
               state_d = S_FETCH;
            end
         end
         S_DRAIN: begin
            // Leave on the edge that empties the pipeline so done trails the last handshake by one cycle.
            if ((count_d == 2'd0) && !inflight_d) begin
               state_d = S_DONE;
            end else begin
               state_d = S_DRAIN;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_DONE);
   end

   // Output FIFO bookkeeping: write returning SRAM data, advance pointers on push/pop.
   always_comb begin
      f_data_d = f_data_q;
      f_sel_d  = f_sel_q;
      f_idx_d  = f_idx_q;
      if (push_s) begin
         f_data_d[wr_ptr_q] = sram_data;
         f_sel_d[wr_ptr_q]  = pipe_sel_q;
         f_idx_d[wr_ptr_q]  = pipe_idx_q;
      end else begin
         f_data_d = f_data_q;
      end
      wr_ptr_d = wr_ptr_q ^ push_s;
      rd_ptr_d = rd_ptr_q ^ pop_s;
      count_d  = count_q + {1'b0, push_s} - {1'b0, pop_s};
   end

   // State register with synchronous reset; a reset discards FIFO contents and any read in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         sel_q       <= 2'd0;
         idx_q       <= {IDX_W{1'b0}};
         addr_hold_q <= {ADDR_W{1'b0}};
         inflight_q  <= 1'b0;
         pipe_sel_q  <= 2'd0;
         pipe_idx_q  <= {IDX_W{1'b0}};
         f_data_q    <= '{default: '0};
         f_sel_q     <= '{default: '0};
         f_idx_q     <= '{default: '0};
         wr_ptr_q    <= 1'b0;
         rd_ptr_q    <= 1'b0;
         count_q     <= 2'd0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         sel_q       <= sel_d;
         idx_q       <= idx_d;
         addr_hold_q <= addr_hold_d;
         inflight_q  <= inflight_d;
         pipe_sel_q  <= pipe_sel_d;
         pipe_idx_q  <= pipe_idx_d;
         f_data_q    <= f_data_d;
         f_sel_q     <= f_sel_d;
         f_idx_q     <= f_idx_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   // Output mapping; the address bus shows the last issued address between reads.
   always_comb begin
      sram_en   = issue_s;
      sram_addr = issue_s ? cur_addr_s : addr_hold_q;
      busy      = busy_q;
      done      = done_q;
      out_valid = (count_q != 2'd0);
      out_data  = f_data_q[rd_ptr_q];
      out_sel   = f_sel_q[rd_ptr_q];
      out_idx   = f_idx_q[rd_ptr_q];
      out_last  = out_valid && (f_idx_q[rd_ptr_q] == LAST_IDX);
   end

   rsa_operand_fetch_chk u_chk (
      .clk   (clk),
      .rst   (rst),
      .push  (push_s),
      .pop   (pop_s),
      .count (count_q)
   );
endmodule

// File: tb/tb_rsa_operand_fetch.sv
// Self-checking bench for rsa_operand_fetch: a beat-sequence reference model plus
// cycle-exact pins for latency, backpressure, restart and mid-run reset.

module tb_rsa_operand_fetch;
   localparam int TOTAL = 192;

   logic        clk = 1'b0;
   logic        rst, start, out_ready;
   logic        busy, done, sram_en, out_valid, out_last;
   logic [7:0]  sram_addr;
   logic [31:0] sram_data = 32'h0;
   logic [31:0] out_data;
   logic [1:0]  out_sel;
   logic [5:0]  out_idx;

   int n_pass = 0, n_total = 0;
   int cyc = 0;
   bit chk_en = 1'b0;

   rsa_operand_fetch dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
      .sram_en(sram_en), .sram_addr(sram_addr), .sram_data(sram_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_sel(out_sel), .out_idx(out_idx), .out_last(out_last)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // SRAM model: one-cycle read latency, data held while not enabled
   always @(posedge clk) if (sram_en) sram_data <= {24'hA5A500, sram_addr};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic chk_true(input string name, input bit ok, input int info);
      n_total++;
      if (ok) n_pass++;
      else $display("FAIL %s: condition false, value %0d (cycle %0d)", name, info, cyc);
   endtask

   function automatic logic [7:0] exp_addr(input int k);
      int s, i, base;
      s = k / 64;
      i = k % 64;
      base = (s == 0) ? 64 : ((s == 1) ? 128 : 0);
      return 8'(base + i);
   endfunction

   // reference model state
   bit   m_busy = 0, m_done = 0, m_after_rst = 1, stall_prev = 0;
   int   m_beat = 0, m_issued = 0, m_out = 0;
   logic [7:0]  m_last_addr = 8'h0;
   logic [31:0] sv_data;
   logic [1:0]  sv_sel;
   logic [5:0]  sv_idx;
   logic        sv_last;
   int   done_count = 0, done_cyc = -1, last_hs_cyc = -1, first_valid_cyc = -1;
   logic [31:0] pin0, pin64, pin191;

   always @(negedge clk) begin
      if (chk_en) begin
         bit pop, nd;
         pop = out_valid && out_ready;
         chk("done", done, m_done);
         chk("busy", busy, m_busy);
         if (m_after_rst) begin
            chk("rst_out_valid", out_valid, 0);
            chk("rst_sram_en", sram_en, 0);
            chk("rst_sram_addr", sram_addr, 0);
         end
         if (out_valid) begin
            chk_true("beat_in_range", m_beat < TOTAL, m_beat);
            if (m_beat < TOTAL) begin
               chk("out_data", out_data, {24'hA5A500, exp_addr(m_beat)});
               chk("out_sel", out_sel, m_beat / 64);
               chk("out_idx", out_idx, m_beat % 64);
               chk("out_last", out_last, (m_beat % 64) == 63);
            end
            if (m_beat == 0 && first_valid_cyc < 0) first_valid_cyc = cyc;
         end
         if (stall_prev) begin
            chk("stall_valid", out_valid, 1);
            chk("stall_data", out_data, sv_data);
            chk("stall_sel", out_sel, sv_sel);
            chk("stall_idx", out_idx, sv_idx);
            chk("stall_last", out_last, sv_last);
         end
         if (sram_en) begin
            chk_true("issue_room", (m_out - int'(pop)) < 2, m_out);
            chk_true("issue_while_busy", m_busy, m_issued);
            chk_true("issue_count", m_issued < TOTAL, m_issued);
            if (m_issued < TOTAL) chk("sram_addr", sram_addr, exp_addr(m_issued));
         end else begin
            chk("sram_addr_hold", sram_addr, m_last_addr);
         end
         // advance the model to the state after the coming edge
         if (rst) begin
            m_busy = 0; m_done = 0; m_beat = 0; m_issued = 0; m_out = 0;
            m_last_addr = 8'h0; stall_prev = 0; m_after_rst = 1;
         end else begin
            m_after_rst = 0;
            nd = pop && (m_beat == TOTAL - 1);
            if (done) begin done_count++; done_cyc = cyc; end
            if (pop) begin
               if (m_beat == 0)   pin0 = out_data;
               if (m_beat == 64)  pin64 = out_data;
               if (m_beat == 191) begin pin191 = out_data; last_hs_cyc = cyc; end
               m_beat++; m_out--;
            end
            if (sram_en) begin m_last_addr = sram_addr; m_issued++; m_out++; end
            if (!m_busy && start) begin
               m_busy = 1; m_beat = 0; m_issued = 0; m_out = 0; first_valid_cyc = -1;
            end else if (m_done) begin
               m_busy = 0;
            end
            m_done = nd;
            stall_prev = out_valid && !out_ready;
            sv_data = out_data; sv_sel = out_sel; sv_idx = out_idx; sv_last = out_last;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   int run_start;

   // mode 0: ready=1; 1: 20-cycle stall at beat 10 then random; 2: start pulses mid-run; 3: stall last beat
   task automatic run_seq(input int mode);
      int dc0, budget, stall_left;
      bit st10, st191, s5, s100;
      dc0 = done_count; budget = 0; stall_left = 0;
      st10 = 0; st191 = 0; s5 = 0; s100 = 0;
      start = 1'b1; out_ready = 1'b1; run_start = cyc;
      tick();
      while (done_count == dc0 && budget < 3000) begin
         start = 1'b0;
         if (mode == 1 && !st10 && m_beat == 10) begin st10 = 1; stall_left = 20; end
         if (mode == 3 && !st191 && m_beat == 191 && out_valid) begin st191 = 1; stall_left = 5; end
         if (stall_left > 0) begin out_ready = 1'b0; stall_left--; end
         else if (mode == 1 && st10) out_ready = 1'($urandom_range(0, 1));
         else out_ready = 1'b1;
         if (mode == 2 && !s5 && m_beat == 5) begin start = 1'b1; s5 = 1; end
         if (mode == 2 && !s100 && m_beat == 100) begin start = 1'b1; s100 = 1; end
         tick();
         budget++;
      end
      start = 1'b0; out_ready = 1'b1;
      chk_true("done_within_budget", done_count != dc0, budget);
      repeat (3) tick();
   endtask

   initial begin
      int dc;
      rst = 1'b1; start = 1'b1; out_ready = 1'b1;
      // T1: reset held two cycles with start high
      tick();
      chk_en = 1'b1;
      tick();
      rst = 1'b0; start = 1'b0;
      repeat (3) tick();

      // T2: full throughput, cycle-exact latency
      dc = done_count;
      run_seq(0);
      chk("t2_first_valid_cyc", first_valid_cyc - run_start, 3);
      chk("t2_last_beat_cyc", last_hs_cyc - run_start, 194);
      chk("t2_done_cyc", done_cyc - run_start, 195);
      chk("t2_done_count", done_count - dc, 1);
      chk("t2_pin_key0", pin0, 32'hA5A5_0040);
      chk("t2_pin_mod0", pin64, 32'hA5A5_0080);
      chk("t2_pin_msg63", pin191, 32'hA5A5_003F);

      // T3: backpressure
      dc = done_count;
      run_seq(1);
      chk("t3_done_count", done_count - dc, 1);

      // T4: start while busy ignored, then identical replay
      dc = done_count;
      run_seq(2);
      chk("t4_done_count", done_count - dc, 1);
      chk("t4_done_cyc", done_cyc - run_start, 195);
      run_seq(0);
      chk("t4_replay_done_cyc", done_cyc - run_start, 195);
      chk("t4_replay_pin_msg63", pin191, 32'hA5A5_003F);

      // T5: reset during beat 70, no done, then clean restart
      dc = done_count;
      start = 1'b1; out_ready = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 400 && m_beat != 70; i++) tick();
      chk("t5_reached_beat70", m_beat, 70);
      chk("t5_head_sel", out_sel, 2'd1);
      chk("t5_head_idx", out_idx, 6'd6);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      repeat (10) tick();
      chk("t5_no_done", done_count - dc, 0);
      run_seq(0);
      chk("t5_restart_first_valid", first_valid_cyc - run_start, 3);
      chk("t5_restart_pin_key0", pin0, 32'hA5A5_0040);

      // T6: stall on the final beat
      run_seq(3);
      chk("t6_last_hs_cyc", last_hs_cyc - run_start, 199);
      chk("t6_done_after_hs", done_cyc - last_hs_cyc, 1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
